// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-stage multiply/divide unit.
package alu_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned XLEN_MAX     = 64;

    // RV32M funct3 encodings
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } muldiv_state_t;

    // Remainder returned on signed overflow (any width, truncated by the user)
    localparam logic [XLEN_MAX-1:0] OVF_REM_ALL = '0;

    // Quotient returned on divide by zero: all ones at the given width
    function automatic logic [XLEN_MAX-1:0] div0_quot(input int unsigned xlen);
        return {XLEN_MAX{1'b1}} >> (XLEN_MAX - xlen);
    endfunction

    // Quotient returned on signed overflow: the most negative value
    function automatic logic [XLEN_MAX-1:0] ovf_quot(input int unsigned xlen);
        return XLEN_MAX'(1) << (xlen - 1);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiplier and restoring
// divider sharing one accumulator and one adder/subtractor.
module muldiv_unit
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] DIV0_QUOT = XLEN'(div0_quot(XLEN));
    localparam logic [XLEN-1:0] OVF_QUOT  = XLEN'(ovf_quot(XLEN));
    localparam logic [XLEN-1:0] OVF_REM   = XLEN'(OVF_REM_ALL);

    muldiv_state_t   r_state;
    muldiv_state_t   w_state_next;
    logic            w_busy_next;
    logic            w_done_next;

    logic            r_busy;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    muldiv_op_t        r_op;
    logic [2*XLEN-1:0] r_acc;      // {hi, lo}: product, or {remainder, quotient}
    logic [XLEN-1:0]   r_opb;      // multiplicand or divisor magnitude
    logic [XLEN-1:0]   r_src1;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_neg_res;
    logic              r_neg_rem;
    logic              r_dz;
    logic              r_ovf;

    muldiv_op_t      w_op;
    logic            w_s1_neg;
    logic            w_s2_neg;
    logic [XLEN-1:0] w_s1_mag;
    logic [XLEN-1:0] w_s2_mag;

    logic            w_is_div;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_add_a;
    logic [XLEN:0]   w_add_b;
    logic [XLEN:0]   w_sum;

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_result;

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

    // Operand conditioning: signedness per op, magnitudes of signed operands
    always_comb begin
        w_op     = muldiv_op_t'(op);
        w_s1_neg = 1'b0;
        w_s2_neg = 1'b0;
        case (w_op)
            OP_MULH, OP_DIV, OP_REM: begin
                w_s1_neg = src1[XLEN-1];
                w_s2_neg = src2[XLEN-1];
            end
            OP_MULHSU: w_s1_neg = src1[XLEN-1];
            default:   ;
        endcase
        w_s1_mag = w_s1_neg ? -src1 : src1;
        w_s2_mag = w_s2_neg ? -src2 : src2;
    end

    // Shared adder: hi + multiplicand, or shifted remainder - divisor
    always_comb begin
        w_is_div = r_op[2];
        w_rem_sh = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_add_a  = w_is_div ? w_rem_sh : {1'b0, r_acc[2*XLEN-1:XLEN]};
        w_add_b  = w_is_div ? ~{1'b0, r_opb} : {1'b0, r_opb};
        w_sum    = w_add_a + w_add_b + (XLEN+1)'(w_is_div);
    end

    // Sign fix-up, special cases and output selection
    always_comb begin
        w_prod = r_neg_res ? -r_acc : r_acc;
        w_quo  = r_neg_res ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
        w_rem  = r_neg_rem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
        w_fix_result = w_prod[XLEN-1:0];
        case (r_op)
            OP_MUL:                       w_fix_result = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix_result = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU: begin
                if (r_dz)       w_fix_result = DIV0_QUOT;
                else if (r_ovf) w_fix_result = OVF_QUOT;
                else            w_fix_result = w_quo;
            end
            OP_REM, OP_REMU: begin
                if (r_dz)       w_fix_result = r_src1;
                else if (r_ovf) w_fix_result = OVF_REM;
                else            w_fix_result = w_rem;
            end
            default: ;
        endcase
    end

    // State register and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    // Next-state logic; busy/done follow the upcoming state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_CALC;
            S_CALC:  if (r_cnt == '0) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        w_busy_next = (w_state_next != S_IDLE);
        w_done_next = (w_state_next == S_DONE);
    end

    // Datapath: operand capture, one iteration per CALC cycle, result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= OP_MUL;
            r_acc     <= '0;
            r_opb     <= '0;
            r_src1    <= '0;
            r_cnt     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_ovf     <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op      <= w_op;
                        r_src1    <= src1;
                        r_cnt     <= CNT_W'(XLEN - 1);
                        r_neg_res <= w_s1_neg ^ w_s2_neg;
                        r_neg_rem <= w_s1_neg;
                        r_dz      <= (src2 == '0);
                        r_ovf     <= ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                                     (src1 == OVF_QUOT) && (src2 == '1);
                        if (op[2]) begin
                            r_acc <= {{XLEN{1'b0}}, w_s1_mag};
                            r_opb <= w_s2_mag;
                        end else begin
                            r_acc <= {{XLEN{1'b0}}, w_s2_mag};
                            r_opb <= w_s1_mag;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_is_div) begin
                        if (!w_sum[XLEN])
                            r_acc <= {w_sum[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
                        else
                            r_acc <= {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
                    end else begin
                        if (r_acc[0])
                            r_acc <= {w_sum, r_acc[XLEN-1:1]};
                        else
                            r_acc <= {1'b0, r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1:1]};
                    end
                end
                S_FIX:   r_result <= w_fix_result;
                default: ;
            endcase
        end
    end

endmodule
